// File: rtl/loot_grab_ctrl.sv
// loot_grab_ctrl: grab/carry/award controller for the hook-and-loot game.
// Tracks one grab at a time: a hook hit on a loot pixel clears that tile,
// the item rides the hook home slowly, and on arrival it is scored and
// removed from the level's loot count.
//
// Ports:
//   clk, resetN      - system clock, asynchronous active-low reset
//   start_level      - level start strobe; reloads loot_left from total_amount
//   hook_draw        - hook drawn at the current pixel
//   hook_extending   - hook travelling outward
//   hook_home        - hook back at its origin
//   loot_type[2:0]   - loot under the current pixel (0 none, 1 gold, 2 rock)
//   total_amount[7:0]- loot items placed in the level
//   loot_collision   - one-clock pulse clearing the hit tile
//   carried_type[2:0]- loot currently on the hook (0 = empty)
//   retract_slow     - hook is loaded and retracts slowly
//   score_valid      - one-clock pulse qualifying score_add
//   score_add[7:0]   - points for the delivered item
//   loot_left[7:0]   - items still on the map
//   level_cleared    - all loot delivered, held until next start_level
module loot_grab_ctrl #(
  parameter logic [7:0] GOLD_VALUE = 8'd50,
  parameter logic [7:0] ROCK_VALUE = 8'd10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_level,
  input  logic       hook_draw,
  input  logic       hook_extending,
  input  logic       hook_home,
  input  logic [2:0] loot_type,
  input  logic [7:0] total_amount,
  output logic       loot_collision,
  output logic [2:0] carried_type,
  output logic       retract_slow,
  output logic       score_valid,
  output logic [7:0] score_add,
  output logic [7:0] loot_left,
  output logic       level_cleared
);

  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CARRY,
    S_AWARD,
    S_CLEARED
  } state_t;

  state_t              state_q, state_d;
  logic                loot_collision_d;
  logic [TYPE_W-1:0]   carried_type_d;
  logic                retract_slow_d;
  logic                score_valid_d;
  logic [COUNT_W-1:0]  score_add_d;
  logic [COUNT_W-1:0]  loot_left_d;
  logic                level_cleared_d;
  logic                hit_c;
  logic [COUNT_W-1:0]  item_value_c;

  assign hit_c = hook_draw && hook_extending && (loot_type != TYPE_W'(0));

  // Points for the item currently on the hook.
  always_comb begin
    item_value_c = COUNT_W'(0);
    if (carried_type == TYPE_W'(1))      item_value_c = GOLD_VALUE;
    else if (carried_type == TYPE_W'(2)) item_value_c = ROCK_VALUE;
  end

  // Next state and next registered output values; start_level wins over all.
  always_comb begin
    state_d          = state_q;
    loot_collision_d = 1'b0;
    carried_type_d   = carried_type;
    retract_slow_d   = retract_slow;
    score_valid_d    = 1'b0;
    score_add_d      = COUNT_W'(0);
    loot_left_d      = loot_left;
    level_cleared_d  = level_cleared;

    if (start_level) begin
      loot_left_d     = total_amount;
      carried_type_d  = TYPE_W'(0);
      retract_slow_d  = 1'b0;
      // An empty level is complete the moment it starts.
      level_cleared_d = (total_amount == COUNT_W'(0));
      state_d         = (total_amount == COUNT_W'(0)) ? S_CLEARED : S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (hit_c) begin
            loot_collision_d = 1'b1;
            carried_type_d   = loot_type;
            retract_slow_d   = 1'b1;
            state_d          = S_CARRY;
          end
        end
        S_CARRY: begin
          // Award values are registered so they appear during the AWARD cycle.
          if (hook_home) begin
            score_valid_d  = 1'b1;
            score_add_d    = item_value_c;
            loot_left_d    = (loot_left == COUNT_W'(0)) ? COUNT_W'(0)
                                                        : loot_left - COUNT_W'(1);
            carried_type_d = TYPE_W'(0);
            retract_slow_d = 1'b0;
            state_d        = S_AWARD;
          end
        end
        S_AWARD: begin
          if (loot_left == COUNT_W'(0)) begin
            level_cleared_d = 1'b1;
            state_d         = S_CLEARED;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_CLEARED: level_cleared_d = 1'b1;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= S_IDLE;
      loot_collision <= 1'b0;
      carried_type   <= TYPE_W'(0);
      retract_slow   <= 1'b0;
      score_valid    <= 1'b0;
      score_add      <= COUNT_W'(0);
      loot_left      <= COUNT_W'(0);
      level_cleared  <= 1'b0;
    end else begin
      state_q        <= state_d;
      loot_collision <= loot_collision_d;
      carried_type   <= carried_type_d;
      retract_slow   <= retract_slow_d;
      score_valid    <= score_valid_d;
      score_add      <= score_add_d;
      loot_left      <= loot_left_d;
      level_cleared  <= level_cleared_d;
    end
  end

endmodule

// File: tb/tb_loot_grab_ctrl.sv
// Self-checking bench for loot_grab_ctrl: directed scenarios plus random
// stimulus compared cycle by cycle against a grab-level reference model.
module tb_loot_grab_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start_level, hook_draw, hook_extending, hook_home;
  logic [2:0] loot_type;
  logic [7:0] total_amount;
  logic       loot_collision;
  logic [2:0] carried_type;
  logic       retract_slow;
  logic       score_valid;
  logic [7:0] score_add;
  logic [7:0] loot_left;
  logic       level_cleared;

  int tests_run = 0;
  int tests_failed = 0;

  loot_grab_ctrl dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_level    (start_level),
    .hook_draw      (hook_draw),
    .hook_extending (hook_extending),
    .hook_home      (hook_home),
    .loot_type      (loot_type),
    .total_amount   (total_amount),
    .loot_collision (loot_collision),
    .carried_type   (carried_type),
    .retract_slow   (retract_slow),
    .score_valid    (score_valid),
    .score_add      (score_add),
    .loot_left      (loot_left),
    .level_cleared  (level_cleared)
  );

  always #5 clk = ~clk;

  // Reference model: a level is in play, an item may be on the hook,
  // and a delivery is followed by a one-cycle scoring window.
  bit       m_in_play;
  bit       m_on_hook;
  bit [2:0] m_item;
  bit       m_scoring;
  int       m_left;
  bit       m_done;
  bit       e_coll, e_sv;
  bit [7:0] e_add;

  function automatic bit [7:0] points(input bit [2:0] t);
    return (t == 3'd1) ? 8'd50 : (t == 3'd2) ? 8'd10 : 8'd0;
  endfunction

  function automatic void model_reset();
    m_in_play = 0; m_on_hook = 0; m_item = 0; m_scoring = 0;
    m_left = 0; m_done = 0; e_coll = 0; e_sv = 0; e_add = 0;
  endfunction

  function automatic void model_step(input bit sl, input bit dr, input bit ex,
                                     input bit hm, input bit [2:0] ty,
                                     input bit [7:0] tot);
    e_coll = 0; e_sv = 0; e_add = 0;
    if (sl) begin
      m_left = tot; m_on_hook = 0; m_item = 0; m_scoring = 0;
      m_done = (tot == 0); m_in_play = (tot != 0);
    end else if (m_scoring) begin
      m_scoring = 0;
      if (m_left == 0) begin m_done = 1; m_in_play = 0; end
    end else if (m_in_play && !m_on_hook && dr && ex && ty != 0) begin
      e_coll = 1; m_on_hook = 1; m_item = ty;
    end else if (m_on_hook && hm) begin
      e_sv = 1; e_add = points(m_item);
      m_on_hook = 0; m_item = 0; m_scoring = 1;
      m_left = (m_left > 0) ? m_left - 1 : 0;
    end
  endfunction

  function automatic bit [22:0] exp_vec();
    return {e_coll, m_item, m_on_hook, e_sv, e_add, 8'(m_left), m_done};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {loot_collision, carried_type, retract_slow, score_valid,
            score_add, loot_left, level_cleared};
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit sl, input bit dr, input bit ex, input bit hm,
                      input bit [2:0] ty, input bit [7:0] tot);
    start_level = sl; hook_draw = dr; hook_extending = ex; hook_home = hm;
    loot_type = ty; total_amount = tot;
    model_step(sl, dr, ex, hm, ty, tot);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    start_level = 0; hook_draw = 0; hook_extending = 0; hook_home = 0;
    loot_type = 0; total_amount = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dut_vec() !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h", dut_vec(), 23'd0);
    end
    resetN = 1'b1;
    // Idle ignores hits and hook_home until a level starts.
    step(0, 1, 1, 0, 3'd1, 8'd4);
    step(0, 0, 0, 1, 3'd2, 8'd4);
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL idle_ignores: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start_and_gold();
    step(1, 0, 0, 0, 3'd0, 8'd3);
    tests_run++;
    if (loot_left !== 8'd3 || level_cleared !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_load: got left=%0d clr=%b expected left=3 clr=0",
               loot_left, level_cleared);
    end
    step(0, 1, 1, 0, 3'd1, 8'd0);
    tests_run++;
    if (loot_collision !== 1'b1 || carried_type !== 3'd1 || retract_slow !== 1'b1) begin
      tests_failed++;
      $display("FAIL gold_hit: got coll=%b type=%0d slow=%b expected 1 1 1",
               loot_collision, carried_type, retract_slow);
    end
    // Repeated hits while carrying must not pulse again.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 3'd2, 8'd0);
      tests_run++;
      if (loot_collision !== 1'b0 || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL carry_no_repulse: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    step(0, 0, 0, 1, 3'd0, 8'd0);
    tests_run++;
    if (score_valid !== 1'b1 || score_add !== 8'd50 || loot_left !== 8'd2 ||
        carried_type !== 3'd0 || retract_slow !== 1'b0) begin
      tests_failed++;
      $display("FAIL gold_award: got sv=%b add=%0d left=%0d type=%0d expected 1 50 2 0",
               score_valid, score_add, loot_left, carried_type);
    end
    step(0, 0, 0, 0, 3'd0, 8'd0);
    tests_run++;
    if (score_valid !== 1'b0 || score_add !== 8'd0 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL award_one_cycle: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_rock_clear();
    step(1, 0, 0, 0, 3'd0, 8'd1);
    step(0, 1, 1, 0, 3'd2, 8'd0);
    step(0, 0, 0, 1, 3'd0, 8'd0);
    tests_run++;
    if (score_add !== 8'd10 || loot_left !== 8'd0 || score_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rock_award: got add=%0d left=%0d sv=%b expected 10 0 1",
               score_add, loot_left, score_valid);
    end
    // Cleared level holds and ignores hits.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, i[0], 3'd1, 8'd0);
      tests_run++;
      if (level_cleared !== 1'b1 || loot_collision !== 1'b0 || loot_left !== 8'd0) begin
        tests_failed++;
        $display("FAIL cleared_hold: got clr=%b coll=%b left=%0d expected 1 0 0",
                 level_cleared, loot_collision, loot_left);
      end
    end
    step(1, 0, 0, 0, 3'd0, 8'd2);
    tests_run++;
    if (level_cleared !== 1'b0 || loot_left !== 8'd2) begin
      tests_failed++;
      $display("FAIL restart_clears: got clr=%b left=%0d expected 0 2",
               level_cleared, loot_left);
    end
  endtask

  task automatic test_no_hit();
    // Not extending, empty pixel, no draw, and a stray home: all ignored.
    step(0, 1, 0, 0, 3'd1, 8'd0);
    step(0, 1, 1, 0, 3'd0, 8'd0);
    step(0, 0, 1, 0, 3'd2, 8'd0);
    step(0, 0, 0, 1, 3'd0, 8'd0);
    tests_run++;
    if (loot_collision !== 1'b0 || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL no_hit: got %h expected %h", dut_vec(), exp_vec());
    end
    // Hit coinciding with start_level is dropped; count reloads.
    step(1, 1, 1, 0, 3'd1, 8'd7);
    tests_run++;
    if (loot_collision !== 1'b0 || loot_left !== 8'd7 || carried_type !== 3'd0) begin
      tests_failed++;
      $display("FAIL hit_with_start: got coll=%b left=%0d type=%0d expected 0 7 0",
               loot_collision, loot_left, carried_type);
    end
  endtask

  task automatic test_zero_total();
    step(1, 0, 0, 0, 3'd0, 8'd0);
    step(0, 1, 1, 0, 3'd1, 8'd0);
    tests_run++;
    if (loot_collision !== 1'b0 || loot_left !== 8'd0 || carried_type !== 3'd0) begin
      tests_failed++;
      $display("FAIL zero_total: got coll=%b left=%0d type=%0d expected 0 0 0",
               loot_collision, loot_left, carried_type);
    end
  endtask

  task automatic test_mid_reset();
    step(1, 0, 0, 0, 3'd0, 8'd3);
    step(0, 1, 1, 0, 3'd1, 8'd0);
    step(0, 0, 0, 0, 3'd0, 8'd0);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (dut_vec() !== 23'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), 23'd0);
    end
    @(posedge clk);
    #1 resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 3'd0, 8'd0);
      tests_run++;
      if (score_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL reset_no_award: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 3'd0, 8'd5);
    for (int g = 0; g < 3; g++) begin
      step(0, 1, 1, 0, 3'(g + 1), 8'd0);
      step(0, 0, 0, 1, 3'd0, 8'd0);
      step(0, 1, 1, 0, 3'd1, 8'd0);   // award cycle: hit ignored
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL back_to_back g%0d: got %h expected %h", g, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (loot_left !== 8'd2) begin
      tests_failed++;
      $display("FAIL back_to_back_left: got %0d expected 2", loot_left);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 4)));
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: got %h expected %h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_and_gold();
    test_rock_clear();
    test_no_hit();
    test_zero_total();
    test_mid_reset();
    test_back_to_back();
    step(1, 0, 0, 0, 3'd0, 8'd3);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
